// File: rtl/unified_cache_port_arbiter.sv
// Round-robin arbiter that funnels NUM_PORT request packets into one
// registered cache issue slot, stamping each winner's port ID into the packet.
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 64
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_ID_WIDTH
`define UNIFIED_CACHE_PACKET_PORT_ID_WIDTH 4
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 63
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_ID_POS_LO
`define UNIFIED_CACHE_PACKET_PORT_ID_POS_LO 56
`endif

module unified_cache_port_arbiter #(
   parameter int NUM_PORT = 4,
   parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS =
      `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
   parameter int UNIFIED_CACHE_PACKET_PORT_ID_WIDTH =
      `UNIFIED_CACHE_PACKET_PORT_ID_WIDTH
) (
   input  logic                                             clk_in,
   input  logic                                             reset_in,
   input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS*NUM_PORT-1:0]
                                                            request_packet_flatted_in,
   output logic [NUM_PORT-1:0]                              request_ack_flatted_out,
   output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0]    issue_packet_out,
   input  logic                                             issue_ack_in,
   output logic                                             busy_out
);

   localparam int PKT   = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
   localparam int IDW   = UNIFIED_CACHE_PACKET_PORT_ID_WIDTH;
   localparam int VPOS  = `UNIFIED_CACHE_PACKET_VALID_POS;
   localparam int IDLO  = `UNIFIED_CACHE_PACKET_PORT_ID_POS_LO;
   localparam int PTR_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

   logic [PTR_W-1:0]    ptr_q;
   logic [PTR_W-1:0]    ptr_d;
   logic [PTR_W-1:0]    winner;
   logic                found;
   logic                slot_free;
   logic [NUM_PORT-1:0] requesting;
   logic [NUM_PORT-1:0] ack_d;
   logic [PKT-1:0]      win_pkt;
   logic [PKT-1:0]      issue_d;
   int                  idx;

   assign busy_out  = issue_packet_out[VPOS];
   assign slot_free = !issue_packet_out[VPOS] || issue_ack_in;

   // A port still seeing its ack must not be picked again this edge
   always_comb begin
      requesting = '0;
      for (int i = 0; i < NUM_PORT; i++) begin
         requesting[i] = request_packet_flatted_in[i*PKT + VPOS] &&
                         !request_ack_flatted_out[i];
      end
   end

   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < NUM_PORT; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_PORT) idx = idx - NUM_PORT;
         if (!found && requesting[idx]) begin
            found  = 1'b1;
            winner = PTR_W'(idx);
         end
      end
   end

   assign win_pkt = request_packet_flatted_in[int'(winner)*PKT +: PKT];

   always_comb begin
      issue_d = issue_packet_out;
      ack_d   = '0;
      ptr_d   = ptr_q;
      if (slot_free) begin
         if (found) begin
            issue_d               = win_pkt;
            issue_d[IDLO +: IDW]  = IDW'(winner);
            ack_d[winner]         = 1'b1;
            ptr_d = (winner == PTR_W'(NUM_PORT-1)) ? '0 : winner + PTR_W'(1);
         end else begin
            issue_d = '0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         issue_packet_out        <= '0;
         request_ack_flatted_out <= '0;
         ptr_q                   <= '0;
      end else begin
         issue_packet_out        <= issue_d;
         request_ack_flatted_out <= ack_d;
         ptr_q                   <= ptr_d;
      end
   end

endmodule

// File: doc/unified_cache_port_arbiter.md
UNIFIED_CACHE_PORT_ARBITER -- requirements
Module: unified_cache_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORT, default 4: number of requesting packet ports; legal range 2..16.
REQ-002 SHALL have parameters UNIFIED_CACHE_PACKET_WIDTH_IN_BITS and UNIFIED_CACHE_PACKET_PORT_ID_WIDTH, defaulting to the global defines of the same names.
REQ-003 SHALL have port clk_in, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_in, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port request_packet_flatted_in, input, PKT*NUM_PORT: one packet per port, where PKT is UNIFIED_CACHE_PACKET_WIDTH_IN_BITS and port i occupies bits [i*PKT +: PKT].
REQ-006 SHALL have port request_ack_flatted_out, output, NUM_PORT: per-port acceptance pulse.
REQ-007 SHALL have port issue_packet_out, output, PKT: registered packet presented to the cache.
REQ-008 SHALL have port issue_ack_in, input, 1: the cache accepted issue_packet_out.
REQ-009 SHALL have port busy_out, output, 1: equals the valid bit of issue_packet_out.

Function
REQ-010 A port SHALL be requesting when its packet bit at `UNIFIED_CACHE_PACKET_VALID_POS` is 1 and its request_ack bit is currently 0.
REQ-011 The output slot SHALL be free when issue_packet_out valid is 0, or when it is 1 and issue_ack_in is 1 in that cycle.
REQ-012 On an edge where the slot is free and at least one port is requesting, SHALL grant exactly one port, the winner.
REQ-013 The winner SHALL be the first requesting port found scanning upward from the priority pointer, wrapping from NUM_PORT-1 to 0.
REQ-014 On a grant, SHALL load the winner's packet into issue_packet_out.
REQ-015 On a grant, the port-ID field (`UNIFIED_CACHE_PACKET_PORT_ID_POS_LO` upward, UNIFIED_CACHE_PACKET_PORT_ID_WIDTH bits) SHALL be overwritten with the winner index, zero-extended.
REQ-016 All other fields of the loaded packet SHALL be copied unchanged.
REQ-017 On a grant, SHALL set request_ack bit[winner] to 1 for exactly one cycle; all other ack bits SHALL be 0 in that cycle.
REQ-018 At most one ack bit SHALL be high in any cycle.
REQ-019 On a grant, the priority pointer SHALL become winner+1, wrapping to 0 after NUM_PORT-1.
REQ-020 On an edge where the slot is free but no port is requesting, issue_packet_out SHALL become all zeros and the pointer SHALL hold.
REQ-021 While valid is 1 and issue_ack_in is 0, issue_packet_out and the pointer SHALL hold unchanged; no ack SHALL be issued.
REQ-022 Back-to-back issue: issue_ack_in=1 with a pending requester SHALL load the next winner on the same edge, with no bubble cycle.
REQ-023 Latency: a request sampled at an edge with the slot free SHALL appear on issue_packet_out, with its ack, in the cycle after that edge.
REQ-024 A port whose ack is high SHALL be excluded from that edge's arbitration, so a packet not yet withdrawn is never issued twice.
REQ-025 A requester that drops valid before being granted SHALL be ignored; no error is flagged.
REQ-026 With all NUM_PORT ports requesting continuously, each port SHALL be granted once in every NUM_PORT consecutive grants.
REQ-027 issue_ack_in SHALL be ignored while issue_packet_out valid is 0.

Reset
REQ-028 On reset_in low, asynchronously: issue_packet_out=0, request_ack_flatted_out=0, busy_out=0, priority pointer=0.
REQ-029 A packet held in the slot when reset asserts mid-operation SHALL be dropped, with no ack emitted.
REQ-030 After reset_in rises, the first grant SHALL be possible on the first rising clk_in edge.

Verification
REQ-031 Scenario: ports 0..3 all valid and held, issue_ack_in=1 every cycle -> grants 0,1,2,3,0 on consecutive cycles; each port's ack high one cycle; port-ID fields 0,1,2,3,0.
REQ-032 Scenario: only port 2 valid, issue_ack_in=0 for 5 cycles then 1 -> issue_packet_out holds the port 2 packet for 6 cycles; ack[2] high only in the first of them; busy_out falls after the ack edge.
REQ-033 Scenario: port 1 keeps valid high during its ack cycle and withdraws one cycle later -> port 1 is never granted twice.
REQ-034 Scenario: pointer=3, ports 0 and 2 valid -> port 0 granted first, then port 2.
REQ-035 Scenario: reset_in driven low mid-cycle while a packet is held -> outputs are zero before the next edge; after release, the lowest valid port from index 0 is granted first.
REQ-036 Scenario: request packet with port-ID field 0x3 arriving on port 1 -> issue_packet_out carries port-ID 1 and an identical data/address/mask.
